// File: rtl/qft_twiddle_feeder.sv
// Feeds amplitudes plus controlled-phase twiddles to the complex multiplier, with a matching valid/index delay line.
// Optional QFT_INVERSE_EN: honour inv and conjugate the rotated twiddle.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 14
`endif

module qft_twiddle_feeder #(
    parameter int LOG_N    = 3,
    parameter int MULT_LAT = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [3:0]                       k,
    input  logic [LOG_N-1:0]                 ctrl_mask,
    input  logic [LOG_N-1:0]                 tgt_mask,
    input  logic                             inv,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [`TOTAL_WIDTH-1:0]   in_re,
    input  logic signed [`TOTAL_WIDTH-1:0]   in_im,
    output logic signed [`TOTAL_WIDTH-1:0]   ar,
    output logic signed [`TOTAL_WIDTH-1:0]   ai,
    output logic signed [`TOTAL_WIDTH-1:0]   br,
    output logic signed [`TOTAL_WIDTH-1:0]   bi,
    output logic                             feed_valid,
    output logic [LOG_N-1:0]                 feed_idx,
    output logic                             prod_valid,
    output logic [LOG_N-1:0]                 prod_idx,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err
);
    localparam int DATA_W = `TOTAL_WIDTH;
    localparam int FRAC_W = `FRAC_WIDTH;
    localparam int N      = 1 << LOG_N;
    localparam int CNT_W  = $clog2(MULT_LAT + 1);
    localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

    // Table entries are held in Q30 and rounded half-up to the working fraction width.
    function automatic logic signed [DATA_W-1:0] round_q30(input longint q30);
        longint r;
        r = (q30 + (longint'(1) <<< (29 - FRAC_W))) >>> (30 - FRAC_W);
        return r[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] cos_tab(input logic [3:0] kk);
        case (kk)
            4'd1:    return round_q30(-64'sd1073741824);
            4'd2:    return round_q30(64'sd0);
            4'd3:    return round_q30(64'sd759250125);
            4'd4:    return round_q30(64'sd992008094);
            4'd5:    return round_q30(64'sd1053110176);
            4'd6:    return round_q30(64'sd1068571464);
            4'd7:    return round_q30(64'sd1072448455);
            4'd8:    return round_q30(64'sd1073418433);
            default: return round_q30(64'sd1073741824);
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sin_tab(input logic [3:0] kk);
        case (kk)
            4'd1:    return round_q30(64'sd0);
            4'd2:    return round_q30(64'sd1073741824);
            4'd3:    return round_q30(64'sd759250125);
            4'd4:    return round_q30(64'sd410903207);
            4'd5:    return round_q30(64'sd209476638);
            4'd6:    return round_q30(64'sd105245103);
            4'd7:    return round_q30(64'sd52686014);
            4'd8:    return round_q30(64'sd26350943);
            default: return round_q30(64'sd0);
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                    state, state_nxt;
    logic [LOG_N-1:0]          idx;
    logic [3:0]                k_q;
    logic [LOG_N-1:0]          ctrl_q, tgt_q;
    logic [CNT_W-1:0]          drain_cnt;
    logic                      xfer;
    logic                      rot_p0;
    logic signed [DATA_W-1:0]  br_p0, bi_p0;
    logic                      vld_p [MULT_LAT];
    logic [LOG_N-1:0]          idx_p [MULT_LAT];

`ifdef QFT_INVERSE_EN
    logic inv_q;
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    assign xfer = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && idx == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == '0 && prod_valid && prod_idx == LAST_IDX) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            k_q       <= '0;
            ctrl_q    <= '0;
            tgt_q     <= '0;
            cfg_err   <= 1'b0;
            drain_cnt <= '0;
`ifdef QFT_INVERSE_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                idx     <= '0;
                k_q     <= k;
                ctrl_q  <= ctrl_mask;
                tgt_q   <= tgt_mask;
                cfg_err <= (k == 4'd0) || (k > 4'(LOG_N));
`ifdef QFT_INVERSE_EN
                inv_q   <= inv;
`endif
            end
            if (xfer && idx != LAST_IDX) idx <= idx + 1'b1;
            if (xfer && idx == LAST_IDX)
                drain_cnt <= CNT_W'(MULT_LAT);
            else if (state == DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - 1'b1;
        end
    end

    // Stage p0: twiddle selection for the amplitude being accepted this cycle.
    always_comb begin
        rot_p0 = ((idx & ctrl_q) == ctrl_q) && ((idx & tgt_q) != '0) && !cfg_err;
        br_p0  = round_q30(64'sd1073741824);
        bi_p0  = '0;
        if (rot_p0) begin
            br_p0 = cos_tab(k_q);
            bi_p0 = sin_tab(k_q);
`ifdef QFT_INVERSE_EN
            if (inv_q) bi_p0 = -sin_tab(k_q);
`endif
        end
    end

    // Stage p1: registered operands to the multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar         <= '0;
            ai         <= '0;
            br         <= '0;
            bi         <= '0;
            feed_valid <= 1'b0;
            feed_idx   <= '0;
        end else if (xfer) begin
            ar         <= in_re;
            ai         <= in_im;
            br         <= br_p0;
            bi         <= bi_p0;
            feed_valid <= 1'b1;
            feed_idx   <= idx;
        end else begin
            ar         <= '0;
            ai         <= '0;
            br         <= '0;
            bi         <= '0;
            feed_valid <= 1'b0;
        end
    end

    // Stages p2..: valid/index line matched to the multiplier latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MULT_LAT; i++) begin
                vld_p[i] <= 1'b0;
                idx_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= feed_valid;
            idx_p[0] <= feed_idx;
            for (int i = 1; i < MULT_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
                idx_p[i] <= idx_p[i-1];
            end
        end
    end

    assign prod_valid = vld_p[MULT_LAT-1];
    assign prod_idx   = idx_p[MULT_LAT-1];

endmodule

// File: tb/tb_qft_twiddle_feeder.sv
// Bench for qft_twiddle_feeder: directed passes plus randomized data, twiddles derived from cos/sin of the rotation angle.
module tb_qft_twiddle_feeder;
    localparam int  LOG_N = 3;
    localparam int  ML    = 3;
    localparam int  N     = 1 << LOG_N;
    localparam int  W     = 16;
    localparam real ONE_R = 16384.0;
    localparam real PI    = 3.14159265358979323846;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [3:0]          k = '0;
    logic [LOG_N-1:0]    ctrl_mask = '0;
    logic [LOG_N-1:0]    tgt_mask = '0;
    logic                inv = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_re = '0;
    logic signed [W-1:0] in_im = '0;
    logic signed [W-1:0] ar, ai, br, bi;
    logic                feed_valid;
    logic [LOG_N-1:0]    feed_idx;
    logic                prod_valid;
    logic [LOG_N-1:0]    prod_idx;
    logic                busy, done, cfg_err;

    qft_twiddle_feeder #(.LOG_N(LOG_N), .MULT_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k),
        .ctrl_mask(ctrl_mask), .tgt_mask(tgt_mask), .inv(inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .feed_valid(feed_valid), .feed_idx(feed_idx),
        .prod_valid(prod_valid), .prod_idx(prod_idx),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int idx; } pend_t;
    pend_t q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    // Model: 0 = idle, 1 = accepting amplitudes, 2 = waiting for the last product.
    int m_phase = 0;
    int m_taken = 0;
    int m_k = 0, m_cm = 0, m_tm = 0;
    bit m_inv = 1'b0, m_err = 1'b0, m_done_prev = 1'b0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void ref_tw(input int i, output int re, output int im);
        real ang;
        re = 16384;
        im = 0;
        if (!m_err && ((i & m_cm) == m_cm) && ((i & m_tm) != 0)) begin
            ang = 2.0 * PI / (2.0 ** m_k);
            re  = $rtoi($floor($cos(ang) * ONE_R + 0.5));
            im  = $rtoi($floor($sin(ang) * ONE_R + 0.5));
`ifdef QFT_INVERSE_EN
            if (m_inv) im = -im;
`endif
        end
    endfunction

    task automatic cycle();
        bit s, iv, rst_seen;
        int re, im, tre, tim;
        bit e_fv, e_pv, e_done;
        int e_fidx, e_pidx, e_ar, e_ai, e_br, e_bi;
        s = start; iv = in_valid; re = in_re; im = in_im;
        rst_seen = 1'b0; e_fv = 1'b0; e_pv = 1'b0; e_done = 1'b0;
        e_fidx = 0; e_pidx = 0; e_ar = 0; e_ai = 0; e_br = 0; e_bi = 0;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_phase = 0; m_err = 1'b0; m_done_prev = 1'b0; m_taken = 0;
            q.delete();
            rst_seen = 1'b1;
        end else begin
            if (m_phase == 0) begin
                if (s) begin
                    m_phase = 1; m_taken = 0;
                    m_k = int'(k); m_cm = int'(ctrl_mask); m_tm = int'(tgt_mask); m_inv = inv;
                    m_err = (m_k == 0) || (m_k > LOG_N);
                end
            end else if (m_phase == 1) begin
                if (iv) begin
                    ref_tw(m_taken, tre, tim);
                    e_fv = 1'b1; e_fidx = m_taken;
                    e_ar = re; e_ai = im; e_br = tre; e_bi = tim;
                    q.push_back('{due: cyc + ML, idx: m_taken});
                    m_taken++;
                    if (m_taken == N) m_phase = 2;
                end
            end else if (m_done_prev) begin
                m_phase = 0;
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e_pv = 1'b1; e_pidx = q[0].idx;
                void'(q.pop_front());
                if (e_pidx == N - 1) e_done = 1'b1;
            end
            m_done_prev = e_done;
        end
        #1;
        chk("in_ready", in_ready, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("done", done, e_done);
        chk("cfg_err", cfg_err, m_err);
        chk("feed_valid", feed_valid, e_fv);
        chk("ar", ar, e_ar);
        chk("ai", ai, e_ai);
        chk("br", br, e_br);
        chk("bi", bi, e_bi);
        if (e_fv || rst_seen) chk("feed_idx", feed_idx, e_fidx);
        chk("prod_valid", prod_valid, e_pv);
        if (e_pv || rst_seen) chk("prod_idx", prod_idx, e_pidx);
    endtask

    // mode: 0 back-to-back, 1 alternating in_valid, 2 random in_valid with stray starts.
    task automatic run_pass(input int kk, input int cm, input int tm, input int mode,
                            input bit inv_i, input bit fixed);
        start = 1'b1; k = 4'(kk); ctrl_mask = 3'(cm); tgt_mask = 3'(tm); inv = inv_i;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 100 && m_phase != 0; c++) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (c % 2 == 0);
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            if (fixed) begin
                in_re = 16'sd16384; in_im = 16'sd0;
            end else begin
                in_re = 16'($urandom); in_im = 16'($urandom);
            end
            start = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            k = 4'($urandom); ctrl_mask = 3'($urandom); tgt_mask = 3'($urandom); inv = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0; start = 1'b0;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        run_pass(2, 3'b010, 3'b001, 0, 1'b0, 1'b1);
        run_pass(3, 3'b100, 3'b100, 0, 1'b0, 1'b0);
        run_pass(0, 3'b000, 3'b111, 0, 1'b0, 1'b0);
        run_pass(3, 3'b000, 3'b011, 1, 1'b0, 1'b0);

        start = 1'b1; k = 4'd2; ctrl_mask = 3'b010; tgt_mask = 3'b001;
        cycle();
        start = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            in_re = 16'($urandom); in_im = 16'($urandom);
            cycle();
        end
        rst_n = 1'b0; in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        run_pass(2, 3'b010, 3'b001, 0, 1'b0, 1'b1);

        run_pass(2, 3'b000, 3'b001, 0, 1'b1, 1'b1);
        run_pass(1, 3'b000, 3'b100, 0, 1'b0, 1'b0);

        repeat (8) run_pass($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                            2, 1'($urandom), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
